// File: rtl/fnd_value_scanner.sv
// fnd_value_scanner: accepts a binary value over valid/ready and converts it
// serially to BCD with shift-add-3, one bit per clock. It holds the last
// committed value and time-multiplexes its digits, a suffix glyph, blanks and
// a dot onto a single 5-bit FND code bus, driven by an internal scan counter.
module fnd_value_scanner #(
  parameter int         DATAWIDTH  = 9,
  parameter int         NUM_DIGITS = 3,
  parameter int         SCAN_POS   = 8,
  parameter int         DIV        = 100_000,
  parameter logic [4:0] SUFFIX     = 5'h17,
  parameter bit         BLANK_LZ   = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_valid,
  input  logic [DATAWIDTH-1:0]        i_data,
  output logic                        o_ready,
  output logic                        o_ovf,
  output logic [$clog2(SCAN_POS)-1:0] o_sel,
  output logic [4:0]                  o_code
);

  localparam int SEL_W = $clog2(SCAN_POS);
  localparam int PRE_W = $clog2(DIV);
  localparam int CNT_W = $clog2(DATAWIDTH + 1);
  // Every 3 input bits add at most one decimal digit, so this scratch width
  // can hold any input value without losing high digits.
  localparam int SCR_N = ((DATAWIDTH + 2) / 3 > NUM_DIGITS) ? (DATAWIDTH + 2) / 3 : NUM_DIGITS;
  localparam int SW    = 4 * SCR_N;
  localparam int HW    = 4 * NUM_DIGITS;

  // Largest value representable on the display: 10^NUM_DIGITS - 1.
  function automatic logic [63:0] max_disp();
    logic [63:0] v;
    v = 64'd1;
    for (int i = 0; i < NUM_DIGITS; i++) v = v * 64'd10;
    return v - 64'd1;
  endfunction

  localparam logic [63:0] MAX_VAL = max_disp();

  // Code shown at scan position p for held digits d.
  function automatic logic [4:0] code_fn(input logic [SEL_W-1:0] p, input logic [HW-1:0] d);
    logic [4:0] c;
    logic [3:0] dig;
    logic       nz;
    c   = 5'h0f;
    dig = 4'h0;
    nz  = 1'b0;
    if (p == SEL_W'(SCAN_POS - 1)) begin
      c = 5'h0a;
    end else if (p == SEL_W'(NUM_DIGITS)) begin
      c = SUFFIX;
    end else if (int'(p) < NUM_DIGITS) begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
        if (k == int'(p)) dig = d[4*k +: 4];
        if (k >= int'(p) && d[4*k +: 4] != 4'h0) nz = 1'b1;
      end
      if (BLANK_LZ && p != '0 && !nz) c = 5'h0f;
      else                            c = {1'b0, dig};
    end
    return c;
  endfunction

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

  state_t                  state_q;
  logic [DATAWIDTH-1:0]    bin_q;
  logic [SW-1:0]           scr_q;
  logic [CNT_W-1:0]        cnt_q;
  logic                    ovf_pend_q;
  logic [HW-1:0]           held_q, held_d;
  logic                    ovf_q, ovf_d;
  logic                    ready_q;
  logic [PRE_W-1:0]        presc_q, presc_d;
  logic [SEL_W-1:0]        sel_q, sel_d;
  logic [4:0]              code_q;
  logic [SW-1:0]           scr_adj;
  logic [SW+DATAWIDTH-1:0] shift_cat;

  // Add 3 to every scratch nibble >= 5, then shift {BCD, bin} left by one.
  always_comb begin
    scr_adj = scr_q;
    for (int i = 0; i < SCR_N; i++) begin
      if (scr_q[4*i +: 4] >= 4'd5) scr_adj[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
    end
    shift_cat = {scr_adj, bin_q} << 1;
  end

  // Held value only changes on COMMIT, and then to a complete conversion.
  always_comb begin
    held_d = held_q;
    ovf_d  = ovf_q;
    if (state_q == COMMIT) begin
      held_d = ovf_pend_q ? {NUM_DIGITS{4'h9}} : scr_q[HW-1:0];
      ovf_d  = ovf_pend_q;
    end
  end

  // Prescaler wraps at DIV-1 and advances the scan position on the wrap edge.
  always_comb begin
    presc_d = presc_q + PRE_W'(1);
    sel_d   = sel_q;
    if (presc_q == PRE_W'(DIV - 1)) begin
      presc_d = '0;
      sel_d   = sel_q + SEL_W'(1);
    end
  end

  // Converter FSM: IDLE accepts, SHIFT runs DATAWIDTH steps, COMMIT publishes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      bin_q      <= '0;
      scr_q      <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      held_q     <= '0;
      ovf_q      <= 1'b0;
      ready_q    <= 1'b1;
    end else begin
      held_q <= held_d;
      ovf_q  <= ovf_d;
      case (state_q)
        IDLE: begin
          if (i_valid) begin
            bin_q      <= i_data;
            scr_q      <= '0;
            cnt_q      <= '0;
            ovf_pend_q <= (64'(i_data) > MAX_VAL);
            ready_q    <= 1'b0;
            state_q    <= SHIFT;
          end
        end
        SHIFT: begin
          scr_q <= shift_cat[SW+DATAWIDTH-1:DATAWIDTH];
          bin_q <= shift_cat[DATAWIDTH-1:0];
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(DATAWIDTH - 1)) state_q <= COMMIT;
        end
        COMMIT: begin
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
        default: begin
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Scan counter and registered code; uses next-state values so a same-edge
  // COMMIT and scan step already show the new digits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_q <= '0;
      sel_q   <= '0;
      code_q  <= 5'h00;
    end else begin
      presc_q <= presc_d;
      sel_q   <= sel_d;
      code_q  <= code_fn(sel_d, held_d);
    end
  end

  assign o_ready = ready_q;
  assign o_ovf   = ovf_q;
  assign o_sel   = sel_q;
  assign o_code  = code_q;

endmodule

// File: tb/tb_fnd_value_scanner.sv
// Directed bench for fnd_value_scanner: main instance plus a BLANK_LZ=0 and
// a NUM_DIGITS=2 instance sharing the same stimulus.
module tb_fnd_value_scanner;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       i_valid = 1'b0;
  logic [8:0] i_data = '0;

  logic       ready_m, ovf_m, ready_nb, ovf_nb, ready_n2, ovf_n2;
  logic [2:0] sel_m, sel_nb, sel_n2;
  logic [4:0] code_m, code_nb, code_n2;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  fnd_value_scanner #(.DATAWIDTH(9), .NUM_DIGITS(3), .SCAN_POS(8), .DIV(4),
                      .SUFFIX(5'h17), .BLANK_LZ(1'b1)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_data(i_data),
    .o_ready(ready_m), .o_ovf(ovf_m), .o_sel(sel_m), .o_code(code_m));

  fnd_value_scanner #(.DATAWIDTH(9), .NUM_DIGITS(3), .SCAN_POS(8), .DIV(4),
                      .SUFFIX(5'h17), .BLANK_LZ(1'b0)) dut_nb (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_data(i_data),
    .o_ready(ready_nb), .o_ovf(ovf_nb), .o_sel(sel_nb), .o_code(code_nb));

  fnd_value_scanner #(.DATAWIDTH(9), .NUM_DIGITS(2), .SCAN_POS(8), .DIV(4),
                      .SUFFIX(5'h17), .BLANK_LZ(1'b1)) dut_n2 (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_data(i_data),
    .o_ready(ready_n2), .o_ovf(ovf_n2), .o_sel(sel_n2), .o_code(code_n2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Expected code for the 3-digit, leading-zero-blanking instance.
  function automatic logic [31:0] exp_code(input int sel, input int val);
    int pw;
    pw = 1;
    for (int i = 0; i < sel; i++) pw = pw * 10;
    if (sel == 7) return 32'h0a;
    if (sel == 3) return 32'h17;
    if (sel > 3) return 32'h0f;
    if (sel > 0 && val < pw) return 32'h0f;
    return 32'((val / pw) % 10);
  endfunction

  task automatic wait_pos(input int p);
    for (int i = 0; i < 40; i++) begin
      if (int'(sel_m) == p) break;
      @(negedge clk);
    end
    chk($sformatf("reach_pos%0d", p), 32'(sel_m), 32'(p));
  endtask

  task automatic convert(input int val);
    chk($sformatf("ready_before_%0d", val), 32'(ready_m), 32'd1);
    i_valid = 1'b1;
    i_data  = 9'(val);
    @(negedge clk);
    i_valid = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (ready_m) break;
      @(negedge clk);
    end
    chk($sformatf("done_%0d", val), 32'(ready_m), 32'd1);
  endtask

  initial begin
    logic [4:0] frame [8];
    int         lowcnt;
    logic       all_rdy;
    int         shown;

    frame = '{5'h00, 5'h0f, 5'h0f, 5'h17, 5'h0f, 5'h0f, 5'h0f, 5'h0a};

    // Reset values while rst is held low
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(ready_m), 32'd1);
    chk("rst_ovf",   32'(ovf_m),   32'd0);
    chk("rst_sel",   32'(sel_m),   32'd0);
    chk("rst_code",  32'(code_m),  32'h00);
    rst = 1'b1;

    // Idle frame: sel steps every 4 clocks
    for (int n = 1; n <= 32; n++) begin
      @(negedge clk);
      if (n == 3) chk("sel_hold", 32'(sel_m), 32'd0);
      if (n % 4 == 0) begin
        chk($sformatf("idle_sel_n%0d", n), 32'(sel_m), 32'((n / 4) % 8));
        chk($sformatf("idle_code_n%0d", n), 32'(code_m), 32'(frame[(n / 4) % 8]));
      end
    end

    // 345: ready low exactly 10 cycles
    chk("ready_pre345", 32'(ready_m), 32'd1);
    i_valid = 1'b1;
    i_data  = 9'd345;
    @(negedge clk);
    i_valid = 1'b0;
    lowcnt  = 0;
    for (int i = 0; i < 30; i++) begin
      if (ready_m) break;
      lowcnt++;
      @(negedge clk);
    end
    chk("busy_cycles", 32'(lowcnt), 32'd10);
    chk("ovf_345", 32'(ovf_m), 32'd0);
    chk("ovf_n2_345", 32'(ovf_n2), 32'd1);
    wait_pos(0); chk("c345_p0", 32'(code_m), 32'h05);
    wait_pos(1); chk("c345_p1", 32'(code_m), 32'h04);
    wait_pos(2); chk("c345_p2", 32'(code_m), 32'h03);
    wait_pos(3); chk("c345_p3", 32'(code_m), 32'h17);

    // 7: leading-zero blanking on/off
    convert(7);
    wait_pos(0); chk("c7_p0", 32'(code_m), 32'h07); chk("c7nb_p0", 32'(code_nb), 32'h07);
    wait_pos(1); chk("c7_p1", 32'(code_m), 32'h0f); chk("c7nb_p1", 32'(code_nb), 32'h00);
    wait_pos(2); chk("c7_p2", 32'(code_m), 32'h0f); chk("c7nb_p2", 32'(code_nb), 32'h00);

    // 511: saturation on the 2-digit instance
    convert(511);
    chk("ovf_n2_511", 32'(ovf_n2), 32'd1);
    chk("ovf_511",    32'(ovf_m),  32'd0);
    wait_pos(0); chk("c511n2_p0", 32'(code_n2), 32'h09); chk("c511_p0", 32'(code_m), 32'h01);
    wait_pos(1); chk("c511n2_p1", 32'(code_n2), 32'h09); chk("c511_p1", 32'(code_m), 32'h01);
    wait_pos(2); chk("c511n2_p2", 32'(code_n2), 32'h17); chk("c511_p2", 32'(code_m), 32'h05);

    // Input while busy is ignored
    i_valid = 1'b1;
    i_data  = 9'd345;
    @(negedge clk);
    i_valid = 1'b0;
    repeat (2) @(negedge clk);
    i_valid = 1'b1;
    i_data  = 9'd12;
    @(negedge clk);
    i_valid = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (ready_m) break;
      @(negedge clk);
    end
    chk("busy_done", 32'(ready_m), 32'd1);
    all_rdy = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      all_rdy = all_rdy & ready_m;
    end
    chk("no_queued", 32'(all_rdy), 32'd1);
    wait_pos(0); chk("ign_p0", 32'(code_m), 32'h05);
    wait_pos(1); chk("ign_p1", 32'(code_m), 32'h04);

    // Reset mid-conversion
    i_valid = 1'b1;
    i_data  = 9'd7;
    @(negedge clk);
    i_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mrst_ready",  32'(ready_m), 32'd1);
    chk("mrst_ovf",    32'(ovf_m),   32'd0);
    chk("mrst_ovf_n2", 32'(ovf_n2),  32'd0);
    chk("mrst_sel",    32'(sel_m),   32'd0);
    chk("mrst_code",   32'(code_m),  32'h00);
    @(negedge clk);
    rst = 1'b1;
    wait_pos(0); chk("post_p0", 32'(code_m), 32'h00);
    wait_pos(1); chk("post_p1", 32'(code_m), 32'h0f);
    wait_pos(2); chk("post_p2", 32'(code_m), 32'h0f);
    chk("post_ready", 32'(ready_m), 32'd1);

    // Back-to-back: 100 then 200 with i_valid held high
    shown = 0;
    chk("b2b_ready0", 32'(ready_m), 32'd1);
    i_valid = 1'b1;
    i_data  = 9'd100;
    for (int k = 0; k <= 22; k++) begin
      @(negedge clk);
      if (k == 10) shown = 100;
      if (k == 21) shown = 200;
      chk($sformatf("b2b_rdy_e%0d", k), 32'(ready_m), 32'((k == 10) || (k >= 21)));
      chk($sformatf("b2b_code_e%0d", k), 32'(code_m), exp_code(int'(sel_m), shown));
      if (k == 0) i_data = 9'd200;
      if (k == 11) i_valid = 1'b0;
    end
    chk("b2b_ovf", 32'(ovf_m), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
